needs_event_scheduler: RTL
==========================

Name: needs_event_scheduler

Overview:
- Sequences every level change of the pet's four needs: salud, energia, hambre, diversion.
- Turns button/sensor requests and periodic decay timing into a single serialized command stream (need, op) with a valid/ready handshake.
- Feeds the needs datapath, so that datapath never sees two updates in one cycle.
- Sits between the input synchronizers/debouncers and the needs/level register block; also drives the display-select for the last user-touched need.

Parameters:
- TICK_DIV, 7500000, clk cycles per base tick (one base_tick pulse per TICK_DIV cycles).
- DECAY_TICKS, 24, base ticks between automatic decrements of each need.
- PLAY_TICKS, 6, base ticks of continuous req_ult per diversion increment.
- SLEEP_TICKS, 12, base ticks of continuous req_sleep per energia increment.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_salud  in  1  heal request, level; synchronized/debounced upstream.
- req_ali  in  1  feed request, level; synchronized/debounced upstream.
- req_ult  in  1  play (ultrasonic presence), level.
- req_sleep  in  1  sleep (gyro at rest), level.
- test_mode  in  1  1 = decay suspended.
- cmd_ready  in  1  datapath accepts the command.
- cmd_valid  out  1  command present.
- cmd_need  out  2  0 salud, 1 energia, 2 hambre, 3 diversion.
- cmd_op  out  1  0 increment, 1 decrement.
- base_tick  out  1  one-cycle pulse each base tick.
- sel_need  out  2  need of the last accepted increment.
- sleeping  out  1  registered copy of req_sleep.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters, pending bits and the round-robin pointer 0. Reset is asynchronous and may arrive mid-handshake; cmd_valid drops immediately and the datapath discards any unaccepted command.
- Base tick:
  - Divider counts 0..TICK_DIV-1.
  - base_tick is high for exactly one cycle when the count wraps.
- Increment pending bits (inc_pend[3:0]):
  - salud: set on a rising edge of req_salud (one registered sample); a held button gives exactly one increment.
  - hambre: set on a rising edge of req_ali.
  - diversion: a play counter advances on base_tick while req_ult is high, clears when req_ult is low, and sets the pending bit and wraps to 0 on reaching PLAY_TICKS.
  - energia: same scheme with req_sleep and SLEEP_TICKS.
- Decay pending bits (dec_pend[3:0]):
  - Each need has a decay counter advanced on base_tick.
  - On reaching DECAY_TICKS-1 at a base_tick, the counter sets dec_pend and wraps to 0.
  - The energia counter holds while sleeping=1.
  - When an increment of a need is accepted, that need's decay counter clears.
- test_mode=1: all decay counters are held at 0 and dec_pend is cleared. Increments still operate.
- Pending bits are sticky. A second event for an already-pending bit merges into it; there is no counting.
- If an event for a bit arrives in the same cycle that bit is accepted, set wins and the bit stays pending.
- Arbitration, evaluated only in IDLE:
  - Any inc_pend beats any dec_pend.
  - Among increments, fixed priority: salud > hambre > diversion > energia.
  - Among decrements, round-robin starting at rr_ptr; rr_ptr moves to the granted index + 1 (mod 4) on acceptance of a decrement.
- FSM:
  - IDLE: if any bit is pending, load cmd_need/cmd_op from the winner, assert cmd_valid and go to ISSUE.
  - ISSUE: hold cmd_valid, cmd_need and cmd_op stable until cmd_valid&cmd_ready. On that cycle, clear the granted pending bit (subject to the set-wins rule), update sel_need for an increment, drop cmd_valid and return to IDLE.
  - A newly higher-priority event during ISSUE does not preempt the current command.
- Latency: a pending bit registered at cycle N gives cmd_valid at N+1. Throughput is at most one command per 2 cycles.
- Widths: counters are sized to clog2 of their parameter. Parameters must be ≥2; there is no overflow because every counter wraps at its terminal count.

Decomposition:
- Shared package needs_pkg:
  - need encodings NEED_SALUD=0, NEED_ENERGIA=1, NEED_HAMBRE=2, NEED_DIVERSION=3;
  - op codes OP_INC=0, OP_DEC=1;
  - FSM state encoding IDLE/ISSUE.
- One sub-module, tick_divider (parameter TICK_DIV, output base_tick), reused by other timing blocks.

Test Plan:
- (Bench parameters for all scenarios: TICK_DIV=4, DECAY_TICKS=3, PLAY_TICKS=2, SLEEP_TICKS=3.)
- Reset check: after release, no requests, cmd_ready=1 -> cmd_valid=0 until the 3rd base_tick. Then four decrement commands are issued, rr order needs 0,1,2,3, each with cmd_op=1.
- Edge triggering: hold req_salud high for 20 cycles with cmd_ready=1 -> exactly one command (need 0, op 0); sel_need=0; the salud decay counter restarts.
- Priority and handshake: raise req_ali and req_salud in the same cycle with cmd_ready=0 for 5 cycles -> cmd_valid=1 with need 0 stable for all 5 cycles. After ready, need 2 is issued next.
- Play and sleep: hold req_ult for 4 base ticks -> 2 diversion increments. Hold req_sleep for 6 base ticks -> 2 energia increments, and no energia decrement during that time.
- Test mode and reset: with test_mode=1 for 10 base ticks, no decrements are issued while increments still are. Assert rst during ISSUE -> cmd_valid=0 in the same cycle and all state returns to its reset values.

Source files
------------

// File: rtl/needs_pkg.sv
// Shared encodings and arbitration helpers for the pet-needs scheduler.
// Need codes double as bit positions in the pending vectors.
package needs_pkg;

    typedef logic [1:0] need_t;

    localparam need_t NEED_SALUD     = 2'd0;
    localparam need_t NEED_ENERGIA   = 2'd1;
    localparam need_t NEED_HAMBRE    = 2'd2;
    localparam need_t NEED_DIVERSION = 2'd3;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Increments use fixed priority: salud > hambre > diversion > energia.
    function automatic need_t pick_inc(input logic [3:0] pend);
        if (pend[NEED_SALUD])
            return NEED_SALUD;
        else if (pend[NEED_HAMBRE])
            return NEED_HAMBRE;
        else if (pend[NEED_DIVERSION])
            return NEED_DIVERSION;
        else
            return NEED_ENERGIA;
    endfunction

    // Round robin: first pending index at or after ptr, wrapping mod 4.
    function automatic need_t pick_rr(input logic [3:0] pend, input need_t ptr);
        need_t idx;
        need_t best;
        best = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx])
                best = idx;
        end
        return best;
    endfunction

endpackage

// File: rtl/needs_event_scheduler_if.sv
// Serialized command channel from the scheduler to the needs datapath.
interface needs_event_scheduler_if;
    import needs_pkg::*;

    logic  cmd_valid;
    logic  cmd_ready;
    need_t cmd_need;
    logic  cmd_op;

    modport master (output cmd_valid, output cmd_need, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_need, input cmd_op, output cmd_ready);

endinterface

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks.
module tick_divider #(
    parameter int TICK_DIV = 7500000
) (
    input  logic clk,
    input  logic rst,
    output logic base_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            base_tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt       <= '0;
            base_tick <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            base_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/needs_event_scheduler.sv
// Collects user requests and periodic decay into sticky pending bits and
// issues them one at a time as (need, op) commands over a valid/ready channel.
module needs_event_scheduler
    import needs_pkg::*;
#(
    parameter int TICK_DIV    = 7500000,
    parameter int DECAY_TICKS = 24,
    parameter int PLAY_TICKS  = 6,
    parameter int SLEEP_TICKS = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_salud,
    input  logic                     req_ali,
    input  logic                     req_ult,
    input  logic                     req_sleep,
    input  logic                     test_mode,
    needs_event_scheduler_if.master  cmd,
    output logic                     base_tick,
    output need_t                    sel_need,
    output logic                     sleeping
);

    localparam int DW = $clog2(DECAY_TICKS);
    localparam int PW = $clog2(PLAY_TICKS);
    localparam int SW = $clog2(SLEEP_TICKS);

    logic                 salud_q;
    logic                 ali_q;
    logic [PW-1:0]        play_cnt;
    logic [SW-1:0]        sleep_cnt;
    logic [3:0][DW-1:0]   decay_cnt;
    logic [3:0]           decay_hold;
    logic [3:0]           inc_pend;
    logic [3:0]           dec_pend;
    logic [3:0]           inc_set;
    logic [3:0]           dec_set;
    logic [3:0]           inc_clr;
    logic [3:0]           dec_clr;
    logic [0:0]           state;
    need_t                rr_ptr;
    logic                 accept;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .base_tick (base_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            salud_q  <= 1'b0;
            ali_q    <= 1'b0;
            sleeping <= 1'b0;
        end else begin
            salud_q  <= req_salud;
            ali_q    <= req_ali;
            sleeping <= req_sleep;
        end
    end

    // Play and sleep credit accumulates only over an unbroken request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_cnt  <= '0;
            sleep_cnt <= '0;
        end else begin
            if (!req_ult)
                play_cnt <= '0;
            else if (base_tick)
                play_cnt <= (play_cnt == PW'(PLAY_TICKS - 1)) ? '0 : play_cnt + 1'b1;

            if (!req_sleep)
                sleep_cnt <= '0;
            else if (base_tick)
                sleep_cnt <= (sleep_cnt == SW'(SLEEP_TICKS - 1)) ? '0 : sleep_cnt + 1'b1;
        end
    end

    assign accept     = (state == ST_ISSUE) && cmd.cmd_valid && cmd.cmd_ready;
    assign decay_hold = {2'b00, sleeping, 1'b0};

    always_comb begin
        inc_clr = '0;
        dec_clr = '0;
        if (accept) begin
            if (cmd.cmd_op == OP_INC)
                inc_clr[cmd.cmd_need] = 1'b1;
            else
                dec_clr[cmd.cmd_need] = 1'b1;
        end
    end

    always_comb begin
        inc_set                 = '0;
        inc_set[NEED_SALUD]     = req_salud & ~salud_q;
        inc_set[NEED_HAMBRE]    = req_ali & ~ali_q;
        inc_set[NEED_DIVERSION] = req_ult & base_tick & (play_cnt == PW'(PLAY_TICKS - 1));
        inc_set[NEED_ENERGIA]   = req_sleep & base_tick & (sleep_cnt == SW'(SLEEP_TICKS - 1));
    end

    // An accepted increment restarts that need's decay, overriding a same-cycle tick.
    always_comb begin
        dec_set = '0;
        for (int i = 0; i < 4; i++)
            dec_set[i] = !test_mode && base_tick && !decay_hold[i] && !inc_clr[i]
                         && (decay_cnt[i] == DW'(DECAY_TICKS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decay_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (test_mode || inc_clr[i])
                    decay_cnt[i] <= '0;
                else if (base_tick && !decay_hold[i])
                    decay_cnt[i] <= dec_set[i] ? '0 : decay_cnt[i] + 1'b1;
            end
        end
    end

    // Set terms are OR-ed after the clear so a coincident event stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_pend <= '0;
            dec_pend <= '0;
        end else begin
            inc_pend <= (inc_pend & ~inc_clr) | inc_set;
            dec_pend <= test_mode ? '0 : ((dec_pend & ~dec_clr) | dec_set);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_need  <= NEED_SALUD;
            cmd.cmd_op    <= OP_INC;
            sel_need      <= NEED_SALUD;
            rr_ptr        <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|inc_pend) begin
                        cmd.cmd_need  <= pick_inc(inc_pend);
                        cmd.cmd_op    <= OP_INC;
                        cmd.cmd_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end else if (|dec_pend) begin
                        cmd.cmd_need  <= pick_rr(dec_pend, rr_ptr);
                        cmd.cmd_op    <= OP_DEC;
                        cmd.cmd_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd.cmd_ready) begin
                        cmd.cmd_valid <= 1'b0;
                        state         <= ST_IDLE;
                        if (cmd.cmd_op == OP_INC)
                            sel_need <= cmd.cmd_need;
                        else
                            rr_ptr <= cmd.cmd_need + 2'd1;
                    end
                end
                default: begin
                    cmd.cmd_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
